// File: rtl/unbalanced_ram_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : unbalanced_ram_reader_if
// Purpose  : Bundles the narrow-side RAM read port (addrb/enb/regceb/doutb)
//            and the outgoing valid/ready word stream of the RAM reader.
// Modports : master - the reader: drives ram_addr/ram_en/ram_regce and the
//                     stream (dout/dout_valid/dout_last); takes ram_dout and
//                     dout_ready.
//            slave  - the environment (RAM + stream consumer), mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface unbalanced_ram_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_en;
  logic                  ram_regce;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;

  modport master (
    output ram_addr, ram_en, ram_regce, dout, dout_valid, dout_last,
    input  ram_dout, dout_ready
  );

  modport slave (
    input  ram_addr, ram_en, ram_regce, dout, dout_valid, dout_last,
    output ram_dout, dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/unbalanced_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : unbalanced_ram_reader
// Purpose  : Read sequencer for the narrow (port B) side of an unbalanced
//            dual-port RAM. A start pulse sweeps length words from base_addr
//            (address wraps modulo 2^ADDR_WIDTH), hides the 1- or 2-cycle RAM
//            read latency with a credit-checked output buffer and presents
//            the words as a valid/ready stream with a last flag.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            start              - request, sampled only while idle
//            base_addr, length  - block descriptor, captured on start
//            busy, done         - block in progress / one-cycle completion
//            bus (master)       - RAM read port + output word stream
//            loop_mode, stop    - only with UNBAL_READER_LOOP_EN defined:
//                                 repeat the block until stop, then finish
// Options  : `define UNBAL_READER_LOOP_EN to enable looping playback.
// Params   : RAM_LATENCY must be 1 or 2; BUF_DEPTH a power of two that is at
//            least RAM_LATENCY+2.
// Revision : 1.0 - initial release
// ============================================================================
module unbalanced_ram_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RAM_LATENCY = 1,
  parameter int BUF_DEPTH   = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [ADDR_WIDTH-1:0] base_addr,
  input  wire logic [ADDR_WIDTH:0]   length,
`ifdef UNBAL_READER_LOOP_EN
  input  wire logic                  loop_mode,
  input  wire logic                  stop,
`endif
  output logic                       busy,
  output logic                       done,
  unbalanced_ram_reader_if.master    bus
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH:0]    len_q;
  logic [ADDR_WIDTH:0]    issued;

  // One bit per read in flight; a bit leaving the top coincides with valid
  // data on ram_dout. pipe_last carries the block-final flag alongside.
  logic [RAM_LATENCY-1:0] pipe_v;
  logic [RAM_LATENCY-1:0] pipe_last;

  logic [DATA_WIDTH-1:0]  buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]   buf_last;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, inflight;

  logic accept, issue, is_last_idx, credit_ok, push, pop;
  logic loop_active, stop_req;

`ifdef UNBAL_READER_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      loop_q <= 1'b0;
    else if (accept) loop_q <= loop_mode;
  end

  assign loop_active = loop_q;
  assign stop_req    = stop;
`else
  assign loop_active = 1'b0;
  assign stop_req    = 1'b0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // Credit uses the registered count only: a pop in this same cycle is not
  // counted, which keeps the check off the dout_ready path.
  assign credit_ok   = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(BUF_DEPTH);
  assign is_last_idx = (issued == (len_q - LEN_ONE));
  assign accept      = (state == S_IDLE) && start;
  assign push        = pipe_v[RAM_LATENCY-1];
  assign pop         = bus.dout_valid && bus.dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (length != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          // At a block boundary keep looping unless stop is requested.
          if (is_last_idx && !(loop_active && !stop_req)) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Finish as soon as the final word leaves, so done lands in the
        // cycle right after that transfer.
        if (inflight == '0 && (count == '0 || (count == CW'(1) && pop)))
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Block descriptor and issue index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
    end else if (accept && length != '0) begin
      base_q <= base_addr;
      len_q  <= length;
      issued <= '0;
    end else if (issue) begin
      issued <= is_last_idx ? '0 : issued + LEN_ONE;
    end
  end

  assign bus.ram_addr = base_q + issued[ADDR_WIDTH-1:0];
  assign bus.ram_en   = issue;

  // Read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      for (int i = RAM_LATENCY-1; i > 0; i--) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_v[0]    <= issue;
      pipe_last[0] <= issue && is_last_idx;
    end
  end

  // Output register stage of the RAM is enabled one cycle after the read.
  generate
    if (RAM_LATENCY == 2) begin : g_regce_pipe
      assign bus.ram_regce = pipe_v[0];
    end else begin : g_regce_tied
      assign bus.ram_regce = 1'b1;
    end
  endgenerate

  // Output buffer (circular FIFO).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_data[i] <= '0;
      buf_last <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= bus.ram_dout;
        buf_last[wr_ptr] <= pipe_last[RAM_LATENCY-1];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.dout_valid = (count != '0);
  assign bus.dout       = buf_data[rd_ptr];
  assign bus.dout_last  = bus.dout_valid && buf_last[rd_ptr];

endmodule
`default_nettype wire

// File: doc/unbalanced_ram_reader.md
Name: unbalanced_ram_reader

Overview:
- Sequencer on the narrow (port B) read side of the unbalanced dual-port RAM.
- On a start pulse it sweeps a block of narrow-word addresses and compensates for the RAM read latency (1 or 2 cycles).
- Presents the words as a valid/ready stream with a last flag.
- Sits directly downstream of the RAM; its read-port outputs drive addrb/enb/regceb and it consumes doutb.

Parameters:
- DATA_WIDTH, 32: narrow word width; matches the RAM port B data width.
- ADDR_WIDTH, 8: narrow address width; matches the RAM port B address width.
- RAM_LATENCY, 1: RAM read latency in cycles; 1 for LOW_LATENCY, 2 for HIGH_PERFORMANCE; other values illegal.
- BUF_DEPTH, 4: output buffer entries; power of two, must be at least RAM_LATENCY+2.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first narrow address, captured on start.
- length  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; captured on start.
- busy  out  1  high from the cycle after an accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse after the last word is accepted.
- ram_addr  out  ADDR_WIDTH  drives addrb.
- ram_en  out  1  drives enb; high only in read-issue cycles.
- ram_regce  out  1  drives regceb; equals ram_en delayed 1 cycle when RAM_LATENCY=2, otherwise tied 1.
- ram_dout  in  DATA_WIDTH  from doutb.
- dout  out  DATA_WIDTH  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready.
- dout_last  out  1  high with the final word of the block.

Behaviour:
- Reset: async, active-low. Clears the FSM to IDLE, the buffer, the in-flight pipeline and all counters. Output values during reset: busy, done, ram_en, dout_valid and dout_last = 0; ram_addr = 0; dout = 0; ram_regce = 0 when RAM_LATENCY=2.
- Reset mid-block: abandons the block; discards buffered and in-flight words; no done pulse.
- FSM states:
  - IDLE: start with length>0 captures base/length → ISSUE. start with length=0 → DONE; no RAM access.
  - ISSUE: issues ram_en=1 at ram_addr = base+issued (mod 2^ADDR_WIDTH) when count+inflight < BUF_DEPTH. After length issues → DRAIN.
  - DRAIN: waits until inflight=0, buffer empty and the last word accepted → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Latency tracking: each issue enters a RAM_LATENCY-deep shift register. When it exits, ram_dout is written into the buffer in the same cycle. The credit check uses the registered count and does not credit a same-cycle pop.
- Stream: dout/dout_valid come from the buffer head. A word transfers when valid&ready. Data and last stay stable while valid&!ready. Order is preserved.
- dout_last: high on the word with index length-1.
- Throughput: with dout_ready held at 1 the block sustains one word per cycle after the initial RAM_LATENCY+1 cycle fill.
- Address wrap: base_addr + length may exceed 2^ADDR_WIDTH. The address wraps to 0 and counting continues.
- start while busy: ignored. base_addr and length changes while busy have no effect.
- Simultaneous buffer write and pop: both happen; count is unchanged.

Optional Feature:
- Macro UNBAL_READER_LOOP_EN.
- Defined: adds input loop_mode (sampled on start) and input stop (level).
  - With loop_mode=1, after issuing index length-1 the issue counter wraps to 0 and re-issues from base_addr indefinitely.
  - dout_last is still flagged on every index length-1.
  - On stop=1, issuing ceases at the next block boundary, the block is completed, then DRAIN → DONE.
  - done pulses once, at the final stop, not at each pass.
- Undefined: the ports are absent and the block is single-shot as above.

Test Plan:
- RAM_LATENCY=1; RAM filled with addr*3; start with base=10, length=5, ready=1 → dout 30,33,36,39,42 on consecutive cycles; last with 42; done 1 cycle after the 42 transfer; 5 ram_en pulses.
- RAM_LATENCY=2; base=250, length=8 → ram_addr 250..255,0,1; dout is the RAM contents at those addresses in order; ram_regce follows ram_en by 1 cycle.
- Ready toggled 1,0,0,1 repeating, length=16 → all 16 words delivered once, in order; count+inflight never exceeds 4; dout stable while stalled.
- length=0 start → done the cycle after start; ram_en never asserted; dout_valid never asserted. A second start while busy → ignored.
- rst_n low mid-block after 3 words → all outputs 0 immediately; a new start with base=0, length=2 then works normally.
- LOOP_EN: loop_mode=1, length=3; stop raised at word 5 → words 0,1,2,0,1,2; last on the 3rd and 6th words; a single done pulse.
